fpu_sequencer: RTL and testbench
================================

// Module: fpu_sequencer
// PURPOSE
//  Sequences one FP operation at a time through fpu_controller on behalf of the core pipeline.
//  Accepts a valid/ready request, holds op/operands stable, drives the stb/ack operand and result handshakes,
//  returns result plus destination tag on a valid/ready response port. Traps unsupported ops and hung units.
// PARAMETERS
//  TAG_W           5    width of destination tag (rd) carried request->response
//  TIMEOUT_CYCLES  256  max cycles from acceptance to fpu_out_stb before abort; >=2
// PORTS
//  clk            in   1       clock; all state on rising edge
//  reset_n        in   1       asynchronous active-low reset
//  req_valid      in   1       request present
//  req_ready      out  1       sequencer can accept (state IDLE)
//  req_op         in   4       op code, fpu_controller encoding (0000 fadd .. 1000 fle)
//  req_a, req_b   in   32      operands
//  req_tag        in   TAG_W   destination tag
//  resp_valid     out  1       response present
//  resp_ready     in   1       consumer takes response
//  resp_data      out  32      result
//  resp_tag       out  TAG_W   tag of the completed request
//  resp_err       out  1       1 = unsupported op or timeout (resp_data = 0)
//  busy           out  1       state != IDLE
//  fpu_op         out  4       to controller op
//  fpu_in1/in2    out  32      to controller in1/in2
//  fpu_in1_stb/in2_stb out 1   operand strobes
//  fpu_in1_ack/in2_ack in  1   operand acks
//  fpu_out        in   32      controller result
//  fpu_out_stb    in   1       result valid
//  fpu_out_ack    out  1       result taken
//  fpu_flush      out  1       1-cycle pulse on timeout; top ORs into FPU reset
//  perf_ops       out  32      completed ops counter (see CONFIGURATION)
//  perf_busy      out  32      busy-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; req_ready=1; all stb/ack/flush=0; resp_valid=0; resp_data=0;
//   resp_tag=0; resp_err=0; fpu_op=0; fpu_in1/in2=0; timeout counter=0; perf counters=0.
//  Supported ops: 0000,0001,0010. Others (0011..1111) never touch the FPU.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly for unsupported op.
//  IDLE: req_ready=1. On req_valid&req_ready edge latch op/a/b/tag into fpu_op/fpu_in1/fpu_in2/tag reg.
//   Supported -> ISSUE, clear counter. Unsupported -> RESP with resp_err=1, resp_data=0.
//  ISSUE: fpu_in1_stb, fpu_in2_stb both 1 from first ISSUE cycle. Each drops independently the cycle after
//   its ack is sampled 1 (per-operand done flag). Both acks same edge -> both done. Both done -> WAIT.
//  WAIT: fpu_out_ack = fpu_out_stb (combinational, WAIT only). Edge with fpu_out_stb=1: resp_data<=fpu_out,
//   resp_err<=0, -> RESP. Single-cycle result handshake.
//  RESP: resp_valid=1, data/tag/err stable until resp_ready sampled 1 -> IDLE. No new request accepted
//   the same edge (req_ready=0 in RESP); min throughput 1 op per 4+FPU cycles.
//  fpu_op/fpu_in1/fpu_in2 held stable from acceptance until next acceptance (controller muxes on op).
//  Timeout: counter increments each cycle in ISSUE/WAIT; when it reaches TIMEOUT_CYCLES-1 with no
//   completion -> fpu_flush=1 for one cycle, stbs/ack forced 0, -> RESP with resp_err=1, resp_data=0.
//   fpu_out_stb on the same edge as expiry: completion wins, no flush.
//  busy = (state != IDLE). resp_valid never depends combinationally on resp_ready.
// CONFIGURATION
//  FPU_SEQ_PERF_EN defined: perf_ops +1 per RESP handshake with resp_err=0; perf_busy +1 each cycle busy=1;
//   both 32-bit wrap at 2^32-1 -> 0; reset to 0.
//  Not defined: perf_ops, perf_busy tied to 0, no counter flops.
// TESTING
//  fadd 3F800000+40000000 tag 7, model acks/out_stb after 3 cycles -> resp 40400000 tag 7 err 0, fpu_op stable.
//  fsub op 0001, in1_ack 2 cycles before in2_ack -> in1_stb drops first, in2_stb held until its ack, correct result.
//  op 0101 -> no stb asserted, resp next cycle err 1 data 0; op 0011 likewise.
//  TIMEOUT_CYCLES=8, model never asserts out_stb -> flush pulse 1 cycle, resp err 1, then fmul 2.0*3.0 -> 40C00000.
//  resp_ready held 0 for 5 cycles -> resp_valid/data stable, req_ready 0, req_valid ignored; reset_n low mid-WAIT -> all reset values.
//  FPU_SEQ_PERF_EN: 3 good ops + 1 illegal -> perf_ops=3, perf_busy = summed busy cycles; undefined -> both 0.

Source files
------------

// File: rtl/fpu_sequencer.sv
// Issues one FP operation at a time to fpu_controller and returns the result with its destination tag.
// Optional performance counters are enabled by defining FPU_SEQ_PERF_EN.
module fpu_sequencer #(
  parameter int TAG_W          = 5,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             busy,
  output logic [3:0]       fpu_op,
  output logic [31:0]      fpu_in1,
  output logic [31:0]      fpu_in2,
  output logic             fpu_in1_stb,
  output logic             fpu_in2_stb,
  input  logic             fpu_in1_ack,
  input  logic             fpu_in2_ack,
  input  logic [31:0]      fpu_out,
  input  logic             fpu_out_stb,
  output logic             fpu_out_ack,
  output logic             fpu_flush,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [31:0]        in1_q, in1_d;
  logic [31:0]        in2_q, in2_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [31:0]        data_q, data_d;
  logic               err_q, err_d;
  logic               done1_q, done1_d;
  logic               done2_q, done2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               expired;

  function automatic logic op_supported(input logic [3:0] op);
    return (op[3:2] == 2'b00) && (op[1:0] != 2'b11);
  endfunction

  assign expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    tag_d       = tag_q;
    data_d      = data_q;
    err_d       = err_q;
    done1_d     = done1_q;
    done2_d     = done2_q;
    cnt_d       = cnt_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    fpu_in1_stb = 1'b0;
    fpu_in2_stb = 1'b0;
    fpu_out_ack = 1'b0;
    fpu_flush   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d  = req_op;
          in1_d = req_a;
          in2_d = req_b;
          tag_d = req_tag;
          if (op_supported(req_op)) begin
            state_d = ISSUE;
            cnt_d   = '0;
            done1_d = 1'b0;
            done2_d = 1'b0;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            data_d  = '0;
          end
        end
      end
      ISSUE: begin
        if (expired) begin
          fpu_flush = 1'b1;
          state_d   = RESP;
          err_d     = 1'b1;
          data_d    = '0;
        end else begin
          fpu_in1_stb = !done1_q;
          fpu_in2_stb = !done2_q;
          done1_d     = done1_q | (fpu_in1_stb & fpu_in1_ack);
          done2_d     = done2_q | (fpu_in2_stb & fpu_in2_ack);
          cnt_d       = cnt_q + 1'b1;
          if (done1_d && done2_d) state_d = WAIT;
        end
      end
      WAIT: begin
        // A result arriving on the expiry edge still completes normally.
        fpu_out_ack = fpu_out_stb;
        if (fpu_out_stb) begin
          data_d  = fpu_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (expired) begin
          fpu_flush = 1'b1;
          state_d   = RESP;
          err_d     = 1'b1;
          data_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      done1_q <= 1'b0;
      done2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
      done1_q <= done1_d;
      done2_q <= done2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign fpu_op    = op_q;
  assign fpu_in1   = in1_q;
  assign fpu_in2   = in2_q;
  assign resp_data = data_q;
  assign resp_tag  = tag_q;
  assign resp_err  = err_q;

`ifdef FPU_SEQ_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_busy_q, perf_busy_d;

  always_comb begin
    perf_ops_d  = perf_ops_q;
    perf_busy_d = perf_busy_q;
    if ((state_q == RESP) && resp_ready && !err_q) perf_ops_d = perf_ops_q + 32'd1;
    if (busy) perf_busy_d = perf_busy_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_ops_q  <= '0;
      perf_busy_q <= '0;
    end else begin
      perf_ops_q  <= perf_ops_d;
      perf_busy_q <= perf_busy_d;
    end
  end

  assign perf_ops  = perf_ops_q;
  assign perf_busy = perf_busy_q;
`else
  assign perf_ops  = '0;
  assign perf_busy = '0;
`endif

endmodule

// File: tb/tb_fpu_sequencer.sv
// Scoreboard bench for fpu_sequencer with a behavioural FPU controller model driving the stb/ack handshakes.
module tb_fpu_sequencer;
  localparam int TAG_W = 5;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [3:0]       req_op = '0;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_err;
  logic             busy;
  logic [3:0]       fpu_op;
  logic [31:0]      fpu_in1, fpu_in2;
  logic             fpu_in1_stb, fpu_in2_stb;
  logic             fpu_in1_ack = 1'b0, fpu_in2_ack = 1'b0;
  logic [31:0]      fpu_out = '0;
  logic             fpu_out_stb = 1'b0;
  logic             fpu_out_ack;
  logic             fpu_flush;
  logic [31:0]      perf_ops, perf_busy;

  fpu_sequencer #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err), .busy(busy),
    .fpu_op(fpu_op), .fpu_in1(fpu_in1), .fpu_in2(fpu_in2),
    .fpu_in1_stb(fpu_in1_stb), .fpu_in2_stb(fpu_in2_stb),
    .fpu_in1_ack(fpu_in1_ack), .fpu_in2_ack(fpu_in2_ack),
    .fpu_out(fpu_out), .fpu_out_stb(fpu_out_stb), .fpu_out_ack(fpu_out_ack),
    .fpu_flush(fpu_flush), .perf_ops(perf_ops), .perf_busy(perf_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   good_ops = 0;
  int   busy_sum = 0;

  // FPU model knobs
  int   dly1 = 1, dly2 = 1, odly = 1;
  bit   never_out = 1'b0;
  int   c1 = 0, c2 = 0, oc = 0;
  bit   got1 = 1'b0, got2 = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] fp_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 4'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == 4'd1 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
    if (op == 4'd2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (op == 4'd0 && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    return 32'h7FC00000;
  endfunction

  // Controller model: acks each operand after its delay, presents the result odly cycles later.
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      #1;
      if (!reset_n || fpu_flush) begin
        fpu_in1_ack = 1'b0; fpu_in2_ack = 1'b0; fpu_out_stb = 1'b0;
        c1 = 0; c2 = 0; oc = 0; got1 = 1'b0; got2 = 1'b0;
      end else if (fpu_out_stb) begin
        fpu_out_stb = 1'b0;
        fpu_out = $urandom;
        got1 = 1'b0; got2 = 1'b0; oc = 0;
      end else begin
        if (fpu_in1_stb) begin
          c1++;
          fpu_in1_ack = (c1 >= dly1);
          if (fpu_in1_ack) got1 = 1'b1;
        end else begin
          c1 = 0; fpu_in1_ack = 1'b0;
        end
        if (fpu_in2_stb) begin
          c2++;
          fpu_in2_ack = (c2 >= dly2);
          if (fpu_in2_ack) got2 = 1'b1;
        end else begin
          c2 = 0; fpu_in2_ack = 1'b0;
        end
        if (got1 && got2 && !fpu_in1_ack && !fpu_in2_ack && !never_out) begin
          oc++;
          if (oc >= odly) begin
            fpu_out_stb = 1'b1;
            fpu_out = fp_ref(fpu_op, fpu_in1, fpu_in2);
          end
        end
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input int d1, input int d2, input int od,
                       input bit nev, input logic [31:0] exp_data, input logic exp_err, input int stall);
    exp_t e;
    int   n, w, in1_cnt, in2_cnt, fl_cnt, exp_lat;
    bit   hold_ok, sup, stall_ok;
    logic [31:0] snap;
    sup = (op < 4'd3);
    exp_lat = !sup ? 0 : (nev ? TMO : (((d1 > d2) ? d1 : d2) + od));
    dly1 = d1; dly2 = d2; odly = od; never_out = nev;
    resp_ready = (stall == 0);
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    chk("req_ready_before", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    e.data = exp_data; e.tag = tag; e.err = exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 4'($urandom); req_a = $urandom; req_b = $urandom; req_tag = TAG_W'($urandom);
    n = 0; in1_cnt = 0; in2_cnt = 0; fl_cnt = 0; hold_ok = 1'b1;
    @(negedge clk);
    while (!resp_valid && n < 300) begin
      if (fpu_in1_stb) in1_cnt++;
      if (fpu_in2_stb) in2_cnt++;
      if (fpu_flush) fl_cnt++;
      if (fpu_op !== op || fpu_in1 !== a || fpu_in2 !== b) hold_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      chk("resp_wait_bound", resp_valid, 1'b1);
    end else begin
      chk("latency", n, exp_lat);
      chk("in1_stb_cycles", in1_cnt, sup ? (nev ? 1 : d1) : 0);
      chk("in2_stb_cycles", in2_cnt, sup ? (nev ? 1 : d2) : 0);
      chk("flush_pulses", fl_cnt, (sup && nev) ? 1 : 0);
      if (sb.size() == 0) begin
        chk("sb_empty", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("resp_data", resp_data, e.data);
        chk("resp_tag", resp_tag, e.tag);
        chk("resp_err", resp_err, e.err);
      end
      snap = resp_data;
      stall_ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
        req_valid = 1'b1; req_op = 4'd0;
        if (!resp_valid || resp_data !== snap || resp_tag !== tag || req_ready !== 1'b0) stall_ok = 1'b0;
        if (fpu_op !== op || fpu_in1 !== a || fpu_in2 !== b) hold_ok = 1'b0;
        @(negedge clk);
      end
      if (stall > 0) chk("stall_stable", stall_ok, 1'b1);
      chk("operand_hold", hold_ok, 1'b1);
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      busy_sum += n + 1 + stall;
      if (!exp_err) good_ops++;
      @(negedge clk);
      chk("idle_after", {resp_valid, busy, req_ready}, 3'b001);
    end
  endtask

  initial begin
    #1;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_ctrl", {resp_valid, busy, fpu_in1_stb, fpu_in2_stb, fpu_out_ack, fpu_flush}, 6'b0);
    chk("rst_data", {resp_data, resp_tag, resp_err, fpu_op}, '0);
    chk("rst_perf", {perf_ops, perf_busy}, 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    do_op(4'd0, 32'h3F800000, 32'h40000000, 5'd7,  3, 3, 3, 1'b0, 32'h40400000, 1'b0, 0);
    do_op(4'd1, 32'h40400000, 32'h3F800000, 5'd12, 1, 3, 2, 1'b0, 32'h40000000, 1'b0, 0);
    do_op(4'd5, 32'h12345678, 32'h9ABCDEF0, 5'd3,  1, 1, 1, 1'b0, 32'h0,        1'b1, 0);
    do_op(4'd3, 32'h3F800000, 32'h3F800000, 5'd4,  1, 1, 1, 1'b0, 32'h0,        1'b1, 0);
    do_op(4'd0, 32'h3F800000, 32'h40000000, 5'd9,  1, 1, 1, 1'b1, 32'h0,        1'b1, 0);
    do_op(4'd2, 32'h40000000, 32'h40400000, 5'd21, 2, 1, 1, 1'b0, 32'h40C00000, 1'b0, 0);
    do_op(4'd0, 32'h40000000, 32'h40000000, 5'd30, 1, 1, 1, 1'b0, 32'h40800000, 1'b0, 5);

`ifdef FPU_SEQ_PERF_EN
    chk("perf_ops", perf_ops, good_ops);
    chk("perf_busy", perf_busy, busy_sum);
`else
    chk("perf_ops_off", perf_ops, 32'd0);
    chk("perf_busy_off", perf_busy, 32'd0);
`endif

    // Asynchronous reset while the sequencer waits for a result.
    dly1 = 1; dly2 = 1; odly = 1; never_out = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd0; req_a = 32'h3F800000; req_b = 32'h40000000; req_tag = 5'd17;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 1'b1);
    chk("mid_rst_ctrl", {resp_valid, busy, fpu_in1_stb, fpu_in2_stb, fpu_out_ack, fpu_flush}, 6'b0);
    chk("mid_rst_data", {resp_data, resp_tag, resp_err, fpu_op, fpu_in1, fpu_in2}, '0);
    chk("mid_rst_perf", {perf_ops, perf_busy}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    do_op(4'd2, 32'h40000000, 32'h40400000, 5'd1, 1, 2, 2, 1'b0, 32'h40C00000, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1);
  end

endmodule
